// File: rtl/audio_playback_sequencer_if.sv
// Bus bundle between the playback sequencer, the sample ROM and the
// downstream PWM/DAC stage.
//   rom_addr     sequencer -> ROM     sample address
//   rom_data     ROM -> sequencer     sample word, combinational from rom_addr
//   sample_out   sequencer -> DAC     registered signed sample
//   sample_valid sequencer -> DAC     sample_out is valid
//   sample_ready DAC -> sequencer     downstream accepts the sample
// master = sequencer side, slave = ROM / DAC side.
interface audio_playback_sequencer_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output rom_addr, sample_out, sample_valid,
        input  rom_data, sample_ready
    );

    modport slave (
        input  rom_addr, sample_out, sample_valid,
        output rom_data, sample_ready
    );
endinterface

// File: rtl/audio_playback_sequencer.sv
// Audio playback sequencer: walks an address window of the sample ROM,
// captures each word and offers it downstream once per sample period over
// a valid/ready handshake. Single-shot or looped playback, stop, and a
// sticky underrun flag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           begin playback (ignored while busy) / abort
//   loop_en               restart at start_addr after end_addr
//   start_addr, end_addr  inclusive window, latched on an accepted start
//   volume [2:0]          attenuation shift, only with AUDIO_VOLUME_EN
//   busy, done, underrun  status (done is a one-cycle pulse)
//   bus                   ROM address/data and downstream sample stream
// Optional feature macro: AUDIO_VOLUME_EN (arithmetic right shift of each
// sample by the latched volume).
module audio_playback_sequencer #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 3125
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]        volume,
`endif
    output logic              busy,
    output logic              done,
    output logic              underrun,
    audio_playback_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, OFFER, PACE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q, win_start, win_end;
    logic [DATA_W-1:0] sample_q;
    logic              valid_q;
    logic              tick;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]        vol_q;
`endif

    assign tick             = (cnt == CNT_W'(CLK_DIV - 1));
    assign bus.rom_addr     = addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            win_start <= '0;
            win_end   <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
`ifdef AUDIO_VOLUME_EN
            vol_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Free-running sample-rate counter; its phase is anchored to the
            // accepted start, not to handshakes.
            if (busy) cnt <= tick ? '0 : cnt + 1'b1;
            // A tick while a sample is still pending is lost, not deferred.
            if (state == OFFER && tick) underrun <= 1'b1;

            if (stop && state != IDLE) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            win_start <= start_addr;
                            win_end   <= end_addr;
                            addr_q    <= start_addr;
                            underrun  <= 1'b0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            state     <= LOAD;
`ifdef AUDIO_VOLUME_EN
                            vol_q     <= volume;
`endif
                        end
                    end
                    LOAD: begin
`ifdef AUDIO_VOLUME_EN
                        sample_q <= $signed(bus.rom_data) >>> vol_q;
`else
                        sample_q <= bus.rom_data;
`endif
                        valid_q  <= 1'b1;
                        state    <= OFFER;
                    end
                    OFFER: begin
                        if (bus.sample_ready) begin
                            valid_q <= 1'b0;
                            if (addr_q != win_end) begin
                                addr_q <= addr_q + 1'b1;
                                state  <= PACE;
                            end else if (loop_en) begin
                                addr_q <= win_start;
                                state  <= PACE;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    PACE: begin
                        if (tick) state <= LOAD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
